// File: rtl/button_pkg.sv
// Shared definitions for the button front end: button index map and debounce counter sizing.
package button_pkg;

  localparam int unsigned NUM_BTNS = 7;
  localparam int unsigned DEBOUNCE_DEFAULT = 4;

  typedef enum logic [2:0] {
    BTN_UP    = 3'd0,
    BTN_DOWN  = 3'd1,
    BTN_LEFT  = 3'd2,
    BTN_RIGHT = 3'd3,
    BTN_B     = 3'd4,
    BTN_A     = 3'd5,
    BTN_START = 3'd6
  } btn_idx_e;

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

  localparam int unsigned CNT_W_DEFAULT = cnt_width(DEBOUNCE_DEFAULT);

endpackage

// File: rtl/button_event_gen_debounce_channel.sv
// One button: two-flop synchronizer, stability counter and accepted level.
// rise_o/fall_o are combinational and true on the edge where held flips.
module debounce_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic btn_i,
  output logic held_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          held_q, held_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept_s;

  always_comb begin
    cnt_d    = cnt_q;
    held_d   = held_q;
    accept_s = 1'b0;
    if (sync2_q == held_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      held_d   = ~held_q;
      cnt_d    = '0;
      accept_s = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      held_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      held_q  <= held_d;
      cnt_q   <= cnt_d;
    end
  end

  assign held_o = held_q;
  assign rise_o = accept_s & ~held_q;
  assign fall_o = accept_s & held_q;

endmodule

// File: rtl/button_event_gen.sv
// Debounced press/release event generator for the seven controller buttons.
// Optional BUTTON_EVENT_SERIALIZE_EN issues at most one event per cycle, lowest index first.
module button_event_gen
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic [NUM_BTNS-1:0] btn_i,
  output logic [NUM_BTNS-1:0] press_o,
  output logic [NUM_BTNS-1:0] release_o,
  output logic [NUM_BTNS-1:0] held_o
);

  logic [NUM_BTNS-1:0] rise_s, fall_s;
  logic [NUM_BTNS-1:0] press_q, press_d;
  logic [NUM_BTNS-1:0] release_q, release_d;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk_i   (clk_i),
      .reset_ni(reset_ni),
      .btn_i   (btn_i[i]),
      .held_o  (held_o[i]),
      .rise_o  (rise_s[i]),
      .fall_o  (fall_s[i])
    );
  end

`ifdef BUTTON_EVENT_SERIALIZE_EN
  // pend_type: 1 = press, 0 = release
  logic [NUM_BTNS-1:0] pend_valid_q, pend_valid_d;
  logic [NUM_BTNS-1:0] pend_type_q, pend_type_d;
  logic                issued_s;

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_type_d  = pend_type_q;
    press_d      = '0;
    release_d    = '0;
    issued_s     = 1'b0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      if (pend_valid_q[i] && !issued_s) begin
        issued_s        = 1'b1;
        pend_valid_d[i] = 1'b0;
        press_d[i]      = pend_type_q[i];
        release_d[i]    = ~pend_type_q[i];
      end else begin
        issued_s = issued_s;
      end
    end
    // A new event against a still-pending opposite event annihilates both.
    for (int i = 0; i < NUM_BTNS; i++) begin
      if (rise_s[i] || fall_s[i]) begin
        if (pend_valid_d[i] && (pend_type_d[i] != rise_s[i])) begin
          pend_valid_d[i] = 1'b0;
        end else begin
          pend_valid_d[i] = 1'b1;
          pend_type_d[i]  = rise_s[i];
        end
      end else begin
        pend_valid_d[i] = pend_valid_d[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      pend_valid_q <= '0;
      pend_type_q  <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_type_q  <= pend_type_d;
    end
  end
`else
  always_comb begin
    press_d   = rise_s;
    release_d = fall_s;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      press_q   <= '0;
      release_q <= '0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen: DEBOUNCE_CYCLES=4 main instance plus a DEBOUNCE_CYCLES=1 instance.
module tb_button_event_gen;

  logic       clk = 1'b0;
  logic       reset_ni;
  logic [6:0] btn, press, rel, held;
  logic [6:0] btn1, press1, rel1, held1;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  button_event_gen #(.DEBOUNCE_CYCLES(4)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .btn_i(btn),
    .press_o(press), .release_o(rel), .held_o(held)
  );

  button_event_gen #(.DEBOUNCE_CYCLES(1)) dut1 (
    .clk_i(clk), .reset_ni(reset_ni), .btn_i(btn1),
    .press_o(press1), .release_o(rel1), .held_o(held1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_ni = 1'b0;
    btn      = 7'h7F;
    btn1     = 7'h00;

    // reset with every button pressed
    for (int c = 1; c <= 5; c++) begin
      step();
      check("rst_press", press, 7'h00);
      check("rst_release", rel, 7'h00);
      check("rst_held", held, 7'h00);
    end
    reset_ni = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step();
      check("rst_all_press", press, (c == 6) ? 7'h7F : 7'h00);
      check("rst_all_held", held, (c >= 6) ? 7'h7F : 7'h00);
    end
    btn = 7'h00;
    for (int c = 1; c <= 12; c++) step();
    check("all_released_held", held, 7'h00);

    // single press and release of A
    btn = 7'h20;
    for (int c = 1; c <= 16; c++) begin
      step();
      check("a_press", press, (c == 6) ? 7'h20 : 7'h00);
      check("a_held", held, (c >= 6) ? 7'h20 : 7'h00);
    end
    btn = 7'h00;
    for (int c = 1; c <= 8; c++) begin
      step();
      check("a_release", rel, (c == 6) ? 7'h20 : 7'h00);
      check("a_held_drop", held, (c >= 6) ? 7'h00 : 7'h20);
    end

    // three-cycle glitch on START
    btn = 7'h40;
    step(); step(); step();
    btn = 7'h00;
    for (int c = 4; c <= 14; c++) begin
      step();
      check("glitch_press", press, 7'h00);
      check("glitch_release", rel, 7'h00);
      check("glitch_held", held, 7'h00);
    end

    // UP and DOWN together
    btn = 7'h03;
    for (int c = 1; c <= 9; c++) begin
      step();
`ifdef BUTTON_EVENT_SERIALIZE_EN
      check("simul_press", press, (c == 7) ? 7'h01 : (c == 8) ? 7'h02 : 7'h00);
`else
      check("simul_press", press, (c == 6) ? 7'h03 : 7'h00);
`endif
    end
    check("simul_held", held, 7'h03);
    btn = 7'h00;
    for (int c = 1; c <= 10; c++) step();
    check("simul_held_drop", held, 7'h00);

    // reset in the middle of a RIGHT debounce
    btn = 7'h08;
    for (int c = 1; c <= 3; c++) begin
      step();
      check("mid_press_pre", press, 7'h00);
    end
    reset_ni = 1'b0;
    step();
    check("mid_rst_held", held, 7'h00);
    reset_ni = 1'b1;
    for (int c = 1; c <= 8; c++) begin
`ifdef BUTTON_EVENT_SERIALIZE_EN
      step();
      check("mid_press_post", press, (c == 7) ? 7'h08 : 7'h00);
`else
      step();
      check("mid_press_post", press, (c == 6) ? 7'h08 : 7'h00);
`endif
      check("mid_held", held, (c >= 6) ? 7'h08 : 7'h00);
    end
    btn = 7'h00;
    for (int c = 1; c <= 10; c++) step();
    check("mid_held_drop", held, 7'h00);

    // single-cycle debounce on B
    btn1 = 7'h10;
    for (int c = 1; c <= 5; c++) begin
      step();
`ifdef BUTTON_EVENT_SERIALIZE_EN
      check("d1_press", press1, (c == 4) ? 7'h10 : 7'h00);
`else
      check("d1_press", press1, (c == 3) ? 7'h10 : 7'h00);
`endif
      check("d1_held", held1, (c >= 3) ? 7'h10 : 7'h00);
    end
    btn1 = 7'h00;
    for (int c = 1; c <= 5; c++) begin
      step();
`ifdef BUTTON_EVENT_SERIALIZE_EN
      check("d1_release", rel1, (c == 4) ? 7'h10 : 7'h00);
`else
      check("d1_release", rel1, (c == 3) ? 7'h10 : 7'h00);
`endif
    end

`ifdef BUTTON_EVENT_SERIALIZE_EN
    // RIGHT pressed and released while queued behind UP and LEFT
    btn1 = 7'h0D;
    step(); step();
    btn1 = 7'h05;
    for (int c = 3; c <= 9; c++) begin
      step();
      check("cancel_press", press1, (c == 4) ? 7'h01 : (c == 5) ? 7'h04 : 7'h00);
      check("cancel_release", rel1, 7'h00);
    end
    btn1 = 7'h00;
    for (int c = 1; c <= 8; c++) step();
    check("cancel_held", held1, 7'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
